// File: rtl/i2c_slave_pkg.sv
// Shared widths, default device address and FSM state encoding for the I2C slave engine.
package i2c_slave_pkg;
    localparam int I2C_ADDR_W = 7;
    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 8;
    localparam logic [I2C_ADDR_W-1:0] DEFAULT_SLAVE_ADDR = 7'h50;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_ACK_DEV,
        ST_REG_ADDR,
        ST_ACK_REG,
        ST_WR_DATA,
        ST_ACK_WR,
        ST_RD_FETCH,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } state_t;
endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the system clock domain and derives single-cycle edge,
// START and STOP pulses from the synchronised levels.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_ck,
    input  logic i_rstn,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);
    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_d_reg;
    logic                   sda_d_reg;
    logic                   scl_s;
    logic                   sda_s;

    // Flops reset to the idle bus level so leaving reset never fakes an edge.
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_d_reg    <= 1'b1;
            sda_d_reg    <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], i_scl};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], i_sda};
            scl_d_reg    <= scl_s;
            sda_d_reg    <= sda_s;
        end
    end

    assign scl_s      = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s      = sda_sync_reg[SYNC_STAGES-1];
    assign o_sda      = sda_s;
    assign o_scl_rise = scl_s & ~scl_d_reg;
    assign o_scl_fall = ~scl_s & scl_d_reg;
    assign o_start    = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
    assign o_stop     = scl_s & scl_d_reg & ~sda_d_reg & sda_s;
endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol engine: address match, register pointer, single-cycle
// strobes to the 16x8 register bank and serialisation of read data onto SDA.
module i2c_slave_ctrl
    import i2c_slave_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  i_ck,
    input  logic                  i_rstn,
    input  logic                  i_scl,
    input  logic                  i_sda,
    output logic                  o_sda_oe,
    output logic                  o_ram_csn,
    output logic                  o_ram_rw,
    output logic [REG_ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0]     o_ram_wdata,
    input  logic [DATA_W-1:0]     i_ram_rdata,
    output logic                  o_busy
);
    logic scl_rise, scl_fall, bus_start, bus_stop, sda_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
        .i_ck      (i_ck),
        .i_rstn    (i_rstn),
        .i_scl     (i_scl),
        .i_sda     (i_sda),
        .o_sda     (sda_s),
        .o_scl_rise(scl_rise),
        .o_scl_fall(scl_fall),
        .o_start   (bus_start),
        .o_stop    (bus_stop)
    );

    state_t                  state_reg;
    logic [DATA_W-1:0]       shift_reg;
    logic [3:0]              bit_cnt_reg;
    logic [REG_ADDR_W-1:0]   ptr_reg;
    logic [1:0]              fetch_ph_reg;
    logic                    ack_on_reg;
    logic                    rw_bit_reg;
    logic                    sda_oe_reg, csn_reg, rw_reg, busy_reg;
    logic [REG_ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]       wdata_reg;
    logic [DATA_W-1:0]       byte_in;

    assign byte_in = {shift_reg[DATA_W-2:0], sda_s};

    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            ptr_reg      <= '0;
            fetch_ph_reg <= '0;
            ack_on_reg   <= 1'b0;
            rw_bit_reg   <= 1'b0;
            sda_oe_reg   <= 1'b0;
            csn_reg      <= 1'b1;
            rw_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
        end else begin
            csn_reg <= 1'b1;
            rw_reg  <= 1'b1;
            if (bus_start) begin
                state_reg   <= ST_DEV_ADDR;
                bit_cnt_reg <= '0;
                ack_on_reg  <= 1'b0;
                sda_oe_reg  <= 1'b0;
                busy_reg    <= 1'b1;
            end else if (bus_stop) begin
                state_reg  <= ST_IDLE;
                ack_on_reg <= 1'b0;
                sda_oe_reg <= 1'b0;
                busy_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE, ST_WAIT_STOP: sda_oe_reg <= 1'b0;
                    ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
                        if (scl_rise) begin
                            shift_reg   <= byte_in;
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            if (bit_cnt_reg == 4'd7) begin
                                ack_on_reg <= 1'b0;
                                if (state_reg == ST_DEV_ADDR) begin
                                    rw_bit_reg <= sda_s;
                                    state_reg  <= (byte_in[DATA_W-1:1] == SLAVE_ADDR) ?
                                                  ST_ACK_DEV : ST_WAIT_STOP;
                                end else if (state_reg == ST_REG_ADDR) begin
                                    ptr_reg   <= byte_in[REG_ADDR_W-1:0];
                                    state_reg <= ST_ACK_REG;
                                end else begin
                                    wdata_reg <= byte_in;
                                    csn_reg   <= 1'b0;
                                    rw_reg    <= 1'b0;
                                    addr_reg  <= ptr_reg;
                                    ptr_reg   <= ptr_reg + REG_ADDR_W'(1);
                                    state_reg <= ST_ACK_WR;
                                end
                            end
                        end
                    end
                    ST_ACK_DEV, ST_ACK_REG, ST_ACK_WR: begin
                        if (scl_fall) begin
                            if (!ack_on_reg) begin
                                sda_oe_reg <= 1'b1;
                                ack_on_reg <= 1'b1;
                            end else begin
                                sda_oe_reg  <= 1'b0;
                                ack_on_reg  <= 1'b0;
                                bit_cnt_reg <= '0;
                                state_reg   <= (state_reg == ST_ACK_DEV) ? ST_REG_ADDR : ST_WR_DATA;
                            end
                        end else if (scl_rise && ack_on_reg && rw_bit_reg && state_reg == ST_ACK_DEV) begin
                            // Read: fetch during the ACK clock so bit 7 replaces the ACK on its falling edge.
                            ack_on_reg   <= 1'b0;
                            fetch_ph_reg <= '0;
                            state_reg    <= ST_RD_FETCH;
                        end
                    end
                    ST_RD_FETCH: begin
                        fetch_ph_reg <= fetch_ph_reg + 2'd1;
                        if (fetch_ph_reg == 2'd0) begin
                            csn_reg  <= 1'b0;
                            rw_reg   <= 1'b1;
                            addr_reg <= ptr_reg;
                        end else if (fetch_ph_reg == 2'd2) begin
                            shift_reg   <= i_ram_rdata;
                            ptr_reg     <= ptr_reg + REG_ADDR_W'(1);
                            bit_cnt_reg <= '0;
                            state_reg   <= ST_RD_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt_reg == 4'd8) begin
                                sda_oe_reg <= 1'b0;
                                state_reg  <= ST_RD_ACK;
                            end else begin
                                sda_oe_reg  <= ~shift_reg[DATA_W-1];
                                shift_reg   <= {shift_reg[DATA_W-2:0], 1'b0};
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            fetch_ph_reg <= '0;
                            state_reg    <= sda_s ? ST_WAIT_STOP : ST_RD_FETCH;
                        end
                    end
                    default: begin
                        sda_oe_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_sda_oe    = sda_oe_reg;
    assign o_ram_csn   = csn_reg;
    assign o_ram_rw    = rw_reg;
    assign o_ram_addr  = addr_reg;
    assign o_ram_wdata = wdata_reg;
    assign o_busy      = busy_reg;
endmodule
